mac_pipe_param: RTL and testbench
=================================

Name: mac_pipe_param

Overview:
Parametrised, pipelined multiply-accumulate engine. It is the successor to the team's fixed 4-bit MAC. It computes LEN-term dot products of IN_W-bit operands, with per-sample signed/unsigned mode, a configurable accumulator width, and saturating or wrapping arithmetic. It adds a valid handshake, a sticky overflow flag and a synchronous vector clear, and feeds downstream filter/DSP blocks as a dot-product slice.

Parameters:
IN_W, 4, operand width (a, b); legal range ≥2.
ACC_W, 12, accumulator/result width; must be ≥ 2*IN_W.
LEN, 4, products per dot product (vector length); legal range ≥1.
SAT, 1, 1 = saturate on overflow, 0 = wrap modulo 2^ACC_W.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
clr  in  1  synchronous vector abort; discards any partial accumulation.
in_valid  in  1  a/b/signed_en valid this cycle.
a  in  IN_W  multiplicand.
b  in  IN_W  multiplier.
signed_en  in  1  1 = two's-complement operands, 0 = unsigned; sampled per sample.
acc_out  out  ACC_W  completed dot product; holds until the next completion.
out_valid  out  1  one-cycle pulse when acc_out updates.
ovf  out  1  overflow occurred anywhere in the completed vector; updates with acc_out.

Behaviour:
- One clock; reset is asynchronous and active-low (rst low → immediate clear, independent of clk).
- Reset values: acc_out=0, out_valid=0, ovf=0; internal counter, accumulator, sticky overflow and pipeline valids all 0.
- Stage 1 (product register):
  - On an edge with in_valid=1 and clr=0: register the full 2*IN_W product, the signed_en, first (cnt==0) and last (cnt==LEN-1) flags, and p_valid=1. Otherwise p_valid=0.
- Sample counter cnt (0..LEN-1):
  - Increments per accepted sample and wraps to 0 after LEN-1.
  - LEN=1: every sample is both first and last.
- Stage 2 (accumulate), on p_valid:
  - Extend the product to ACC_W+1 bits: sign-extend if its registered signed_en=1, zero-extend otherwise.
  - If first: acc ← ext(p). Else acc ← acc + ext(p).
  - Compute in ACC_W+1 bits; overflow is detected against the ACC_W range of the sample's mode.
  - Signed range: [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Unsigned range: [0, 2^ACC_W-1].
  - SAT=1: clamp to the range bound. SAT=0: keep the low ACC_W bits.
- Sticky overflow: set by any overflowing step in the vector; the first sample reloads it with that sample's own overflow.
- On last: on the following edge acc_out ← final acc, ovf ← final sticky, out_valid=1 for exactly one cycle.
- Latency: the last sample is sampled at edge k; acc_out/out_valid/ovf are valid after edge k+2.
- Throughput is one sample per cycle. Back-to-back vectors need no idle cycles. Gaps in in_valid are allowed anywhere; the pipeline stalls nothing and just skips.
- clr=1:
  - Resets cnt to 0 and zeroes the stage-1/stage-2 valids and the sticky overflow, so any in-flight result is dropped.
  - acc_out and ovf hold their last values; out_valid=0 next cycle.
  - clr and in_valid together: clr wins and the sample is dropped.
- Mixed signed_en within one vector is legal; each product uses its own mode. Overflow range is checked using the mode of the current sample.
- Reset asserted mid-vector: all state returns to reset values; the next accepted sample is treated as first.

Test Plan:
- Unsigned, defaults (IN_W=4, ACC_W=12, LEN=4, SAT=1): four samples a=15, b=15 on consecutive cycles → acc_out=900 (12'h384), ovf=0, out_valid pulses once, 2 cycles after the 4th sample.
- Saturation, ACC_W=8, LEN=2, SAT=1: unsigned 15×15 twice → acc_out=8'hFF, ovf=1. Same with SAT=0 → acc_out=194 (8'hC2), ovf=1.
- Signed, ACC_W=8, LEN=4, SAT=1: a=4'b1000 (-8), b=7, ×4 → -224 clamps to 8'h80, ovf=1. With ACC_W=12 → 12'hF20, ovf=0.
- Gapped plus back-to-back vectors, defaults: in_valid pattern 1,0,1,1,0,0,1 with a=1, b=2..5, followed immediately by a second vector of four a=1, b=1 → results 14 then 4, each pulsing once, and ovf of the second vector is 0 even when the first overflowed.
- clr mid-vector: two samples of 3×3, then clr together with a valid sample, then four samples of 1×1 → only one out_valid, acc_out=4; the dropped sample is not counted.
- Reset mid-vector: rst low for 1 ns between edges after two samples → all outputs 0 immediately; the next four samples of 2×2 → acc_out=16.

Source files
------------

// File: rtl/mac_pipe_param_if.sv
//------------------------------------------------------------------------------
// Module  : mac_pipe_param_if
// Brief   : Sample/result bundle for the pipelined dot-product MAC.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mac_pipe_param_if #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 12
);
  logic             clr;
  logic             in_valid;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic             signed_en;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             ovf;

  modport master (
    output clr, in_valid, a, b, signed_en,
    input  acc_out, out_valid, ovf
  );

  modport slave (
    input  clr, in_valid, a, b, signed_en,
    output acc_out, out_valid, ovf
  );
endinterface

`default_nettype wire

// File: rtl/mac_pipe_param.sv
//------------------------------------------------------------------------------
// Module  : mac_pipe_param
// Brief   : Pipelined LEN-term dot-product MAC, per-sample signed mode,
//           saturating or wrapping accumulation, sticky overflow per vector.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_pipe_param #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 12,
  parameter int LEN   = 4,
  parameter int SAT   = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mac_pipe_param_if.slave  bus
);

  localparam int c_CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int c_PW    = 2 * IN_W;
  localparam int c_EW    = ACC_W + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(LEN - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_PW-1:0]    r_prod;
  logic               r_p_signed;
  logic               r_p_first;
  logic               r_p_last;
  logic               r_p_valid;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sticky;
  logic               r_a_valid;
  logic               r_a_last;
  logic [ACC_W-1:0]   r_acc_out;
  logic               r_out_valid;
  logic               r_ovf;

  logic signed [c_PW-1:0] w_as;
  logic signed [c_PW-1:0] w_bs;
  logic [c_PW-1:0]        w_au;
  logic [c_PW-1:0]        w_bu;
  logic [c_PW-1:0]        w_prod_s;
  logic [c_PW-1:0]        w_prod_u;
  logic [c_PW-1:0]        w_prod;

  assign w_as     = c_PW'($signed(bus.a));
  assign w_bs     = c_PW'($signed(bus.b));
  assign w_au     = c_PW'(bus.a);
  assign w_bu     = c_PW'(bus.b);
  assign w_prod_s = $unsigned(w_as * w_bs);
  assign w_prod_u = w_au * w_bu;
  assign w_prod   = bus.signed_en ? w_prod_s : w_prod_u;

  logic [c_EW-1:0]  w_ext_p;
  logic [c_EW-1:0]  w_ext_acc;
  logic [c_EW-1:0]  w_sum;
  logic             w_step_ovf;
  logic [ACC_W-1:0] w_next_acc;
  logic             w_next_sticky;

  // The running sum is re-extended in the current sample's mode, so the
  // one-bit headroom always holds the true sign (signed) or carry (unsigned).
  always_comb begin
    w_ext_p       = r_p_signed ? c_EW'($signed(r_prod)) : c_EW'(r_prod);
    w_ext_acc     = '0;
    if (!r_p_first) begin
      w_ext_acc   = r_p_signed ? c_EW'($signed(r_acc)) : c_EW'(r_acc);
    end
    w_sum         = w_ext_acc + w_ext_p;
    w_step_ovf    = r_p_signed ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    w_next_acc    = w_sum[ACC_W-1:0];
    if ((SAT != 0) && w_step_ovf) begin
      if (!r_p_signed) begin
        w_next_acc = '1;
      end else if (w_sum[ACC_W]) begin
        w_next_acc = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        w_next_acc = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
    w_next_sticky = w_step_ovf | (~r_p_first & r_sticky);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_prod      <= '0;
      r_p_signed  <= 1'b0;
      r_p_first   <= 1'b0;
      r_p_last    <= 1'b0;
      r_p_valid   <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_a_valid   <= 1'b0;
      r_a_last    <= 1'b0;
      r_acc_out   <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.clr) begin
        r_cnt     <= '0;
        r_p_valid <= 1'b0;
        r_a_valid <= 1'b0;
        r_sticky  <= 1'b0;
      end else begin
        r_p_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_prod     <= w_prod;
          r_p_signed <= bus.signed_en;
          r_p_first  <= (r_cnt == '0);
          r_p_last   <= (r_cnt == c_LAST);
          r_cnt      <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end
        r_a_valid <= r_p_valid;
        if (r_p_valid) begin
          r_acc    <= w_next_acc;
          r_sticky <= w_next_sticky;
          r_a_last <= r_p_last;
        end
        if (r_a_valid && r_a_last) begin
          r_acc_out   <= r_acc;
          r_ovf       <= r_sticky;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.acc_out   = r_acc_out;
  assign bus.out_valid = r_out_valid;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_pipe_param.sv
//------------------------------------------------------------------------------
// Module  : tb_mac_pipe_param
// Brief   : Directed bench driving one sample stream into four MAC variants.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mac_pipe_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       vin = 1'b0;
  logic [3:0] sa  = '0;
  logic [3:0] sb  = '0;
  logic       sg  = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pc0 = 0;
  int pc1 = 0;

  always #5 clk = ~clk;

  // d0: defaults; d1: ACC_W=8 LEN=2 SAT=1; d2: ACC_W=8 LEN=2 SAT=0; d3: ACC_W=8 LEN=4 SAT=1
  mac_pipe_param_if #(.IN_W(4), .ACC_W(12)) i0 ();
  mac_pipe_param_if #(.IN_W(4), .ACC_W(8))  i1 ();
  mac_pipe_param_if #(.IN_W(4), .ACC_W(8))  i2 ();
  mac_pipe_param_if #(.IN_W(4), .ACC_W(8))  i3 ();

  assign i0.clr = clr; assign i0.in_valid = vin; assign i0.a = sa; assign i0.b = sb; assign i0.signed_en = sg;
  assign i1.clr = clr; assign i1.in_valid = vin; assign i1.a = sa; assign i1.b = sb; assign i1.signed_en = sg;
  assign i2.clr = clr; assign i2.in_valid = vin; assign i2.a = sa; assign i2.b = sb; assign i2.signed_en = sg;
  assign i3.clr = clr; assign i3.in_valid = vin; assign i3.a = sa; assign i3.b = sb; assign i3.signed_en = sg;

  mac_pipe_param #(.IN_W(4), .ACC_W(12), .LEN(4), .SAT(1)) d0 (.clk(clk), .rst(rst), .bus(i0));
  mac_pipe_param #(.IN_W(4), .ACC_W(8),  .LEN(2), .SAT(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
  mac_pipe_param #(.IN_W(4), .ACC_W(8),  .LEN(2), .SAT(0)) d2 (.clk(clk), .rst(rst), .bus(i2));
  mac_pipe_param #(.IN_W(4), .ACC_W(8),  .LEN(4), .SAT(1)) d3 (.clk(clk), .rst(rst), .bus(i3));

  always @(posedge clk) begin
    #1;
    if (i0.out_valid) pc0 = pc0 + 1;
    if (i1.out_valid) pc1 = pc1 + 1;
  end

  task automatic sample(input logic [3:0] av, input logic [3:0] bv, input logic s,
                        input logic v, input logic c);
    @(negedge clk);
    sa = av; sb = bv; sg = s; vin = v; clr = c;
  endtask

  task automatic idle3();
    sample(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (i0.acc_out !== 12'h000) begin failures++; $display("FAIL rst_acc got=%0h exp=0", i0.acc_out); end
    checks++; if (i0.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", i0.out_valid); end
    checks++; if (i0.ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", i0.ovf); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned();
    int b0, b1;
    b0 = pc0; b1 = pc1;
    for (int i = 0; i < 4; i++) sample(4'd15, 4'd15, 1'b0, 1'b1, 1'b0);
    sample(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (i0.out_valid !== 1'b0) begin failures++; $display("FAIL uns_early_valid got=%0b exp=0", i0.out_valid); end
    @(negedge clk);
    checks++; if (i0.out_valid !== 1'b1) begin failures++; $display("FAIL uns_valid got=%0b exp=1", i0.out_valid); end
    checks++; if (i0.acc_out !== 12'h384) begin failures++; $display("FAIL uns_acc got=%0h exp=384", i0.acc_out); end
    checks++; if (i0.ovf !== 1'b0) begin failures++; $display("FAIL uns_ovf got=%0b exp=0", i0.ovf); end
    checks++; if (i1.acc_out !== 8'hFF) begin failures++; $display("FAIL sat_acc got=%0h exp=ff", i1.acc_out); end
    checks++; if (i1.ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", i1.ovf); end
    checks++; if (i2.acc_out !== 8'hC2) begin failures++; $display("FAIL wrap_acc got=%0h exp=c2", i2.acc_out); end
    checks++; if (i2.ovf !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%0b exp=1", i2.ovf); end
    checks++; if (i3.acc_out !== 8'hFF) begin failures++; $display("FAIL sat4_acc got=%0h exp=ff", i3.acc_out); end
    @(negedge clk);
    checks++; if (i0.out_valid !== 1'b0) begin failures++; $display("FAIL uns_pulse_end got=%0b exp=0", i0.out_valid); end
    checks++; if (i0.acc_out !== 12'h384) begin failures++; $display("FAIL uns_hold got=%0h exp=384", i0.acc_out); end
    checks++; if (pc0 - b0 !== 1) begin failures++; $display("FAIL uns_pulses got=%0d exp=1", pc0 - b0); end
    checks++; if (pc1 - b1 !== 2) begin failures++; $display("FAIL sat_pulses got=%0d exp=2", pc1 - b1); end
  endtask

  task automatic test_signed();
    for (int i = 0; i < 4; i++) sample(4'b1000, 4'd7, 1'b1, 1'b1, 1'b0);
    idle3();
    checks++; if (i0.acc_out !== 12'hF20) begin failures++; $display("FAIL sgn12_acc got=%0h exp=f20", i0.acc_out); end
    checks++; if (i0.ovf !== 1'b0) begin failures++; $display("FAIL sgn12_ovf got=%0b exp=0", i0.ovf); end
    checks++; if (i3.acc_out !== 8'h80) begin failures++; $display("FAIL sgn8_acc got=%0h exp=80", i3.acc_out); end
    checks++; if (i3.ovf !== 1'b1) begin failures++; $display("FAIL sgn8_ovf got=%0b exp=1", i3.ovf); end
    checks++; if (i1.acc_out !== 8'h90) begin failures++; $display("FAIL sgn_len2_acc got=%0h exp=90", i1.acc_out); end
    checks++; if (i1.ovf !== 1'b0) begin failures++; $display("FAIL sgn_len2_ovf got=%0b exp=0", i1.ovf); end
    checks++; if (i2.acc_out !== 8'h90) begin failures++; $display("FAIL sgn_wrap_acc got=%0h exp=90", i2.acc_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int b0;
    b0 = pc0;
    sample(4'd1, 4'd2, 1'b0, 1'b1, 1'b0);
    sample(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sample(4'd1, 4'd3, 1'b0, 1'b1, 1'b0);
    sample(4'd1, 4'd4, 1'b0, 1'b1, 1'b0);
    sample(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sample(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    sample(4'd1, 4'd5, 1'b0, 1'b1, 1'b0);
    sample(4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    sample(4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    sample(4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    checks++; if (i0.out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got=%0b exp=1", i0.out_valid); end
    checks++; if (i0.acc_out !== 12'd14) begin failures++; $display("FAIL gap_acc got=%0d exp=14", i0.acc_out); end
    checks++; if (i3.acc_out !== 8'd14) begin failures++; $display("FAIL gap8_acc got=%0d exp=14", i3.acc_out); end
    checks++; if (i3.ovf !== 1'b0) begin failures++; $display("FAIL sticky_reload got=%0b exp=0", i3.ovf); end
    sample(4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    checks++; if (i0.out_valid !== 1'b0) begin failures++; $display("FAIL gap_pulse_end got=%0b exp=0", i0.out_valid); end
    idle3();
    checks++; if (i0.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", i0.out_valid); end
    checks++; if (i0.acc_out !== 12'd4) begin failures++; $display("FAIL b2b_acc got=%0d exp=4", i0.acc_out); end
    checks++; if (i0.ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf got=%0b exp=0", i0.ovf); end
    @(negedge clk);
    checks++; if (pc0 - b0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pc0 - b0); end
  endtask

  task automatic test_clr();
    int b0, b1;
    b0 = pc0; b1 = pc1;
    sample(4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    sample(4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    sample(4'd3, 4'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) sample(4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
    idle3();
    checks++; if (i0.out_valid !== 1'b1) begin failures++; $display("FAIL clr_valid got=%0b exp=1", i0.out_valid); end
    checks++; if (i0.acc_out !== 12'd4) begin failures++; $display("FAIL clr_acc got=%0d exp=4", i0.acc_out); end
    checks++; if (i1.acc_out !== 8'd2) begin failures++; $display("FAIL clr_len2_acc got=%0d exp=2", i1.acc_out); end
    @(negedge clk);
    checks++; if (pc0 - b0 !== 1) begin failures++; $display("FAIL clr_pulses got=%0d exp=1", pc0 - b0); end
    checks++; if (pc1 - b1 !== 2) begin failures++; $display("FAIL clr_len2_pulses got=%0d exp=2", pc1 - b1); end
  endtask

  task automatic test_async_reset();
    int b0;
    sample(4'd2, 4'd2, 1'b0, 1'b1, 1'b0);
    sample(4'd2, 4'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    vin = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (i0.acc_out !== 12'h000) begin failures++; $display("FAIL arst_acc got=%0h exp=0", i0.acc_out); end
    checks++; if (i1.acc_out !== 8'h00) begin failures++; $display("FAIL arst_len2_acc got=%0h exp=0", i1.acc_out); end
    checks++; if (i0.out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0b exp=0", i0.out_valid); end
    checks++; if (i0.ovf !== 1'b0) begin failures++; $display("FAIL arst_ovf got=%0b exp=0", i0.ovf); end
    #1 rst = 1'b1;
    b0 = pc0;
    for (int i = 0; i < 4; i++) sample(4'd2, 4'd2, 1'b0, 1'b1, 1'b0);
    idle3();
    checks++; if (i0.acc_out !== 12'd16) begin failures++; $display("FAIL arst_next_acc got=%0d exp=16", i0.acc_out); end
    checks++; if (i1.acc_out !== 8'd8) begin failures++; $display("FAIL arst_len2_next got=%0d exp=8", i1.acc_out); end
    @(negedge clk);
    checks++; if (pc0 - b0 !== 1) begin failures++; $display("FAIL arst_pulses got=%0d exp=1", pc0 - b0); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
